// File: rtl/button_conditioner.sv
// Multi-channel button front end: synchroniser, tick-gated debouncer, edge pulse,
// long-press and auto-repeat pulses. Each channel is an independent lane instance.

module button_conditioner_lane #(
  parameter int SYNC_STAGES  = 2,
  parameter int PRESS_LEVEL  = 0,
  parameter int DEB_TICKS    = 4,
  parameter int EDGE_MODE    = 0,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic iClk,
  input  logic iRsn,
  input  logic iEnClk,
  input  logic iButton,
  output logic oLevel,
  output logic oSyncButton,
  output logic oLongPress,
  output logic oRepeat
);

  localparam logic PRESS = (PRESS_LEVEL != 0);
  localparam logic IDLE  = ~PRESS;
  localparam int   MAXT  = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int   DW    = $clog2(DEB_TICKS + 1);
  localparam int   HW    = $clog2(MAXT + 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DW-1:0]          deb_q, deb_d;
  logic                   level_q, level_d;
  logic                   level_d1_q;
  logic                   edge_sel;
  logic                   sync_pulse_q;
  state_t                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   long_q, long_d;
  logic                   rep_q, rep_d;
  logic                   released;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) sync_q <= {SYNC_STAGES{IDLE}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], iButton};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A differing sample must persist for DEB_TICKS consecutive ticks; any agreeing tick restarts.
  always_comb begin
    deb_d   = deb_q;
    level_d = level_q;
    if (iEnClk) begin
      if (s == level_q) begin
        deb_d = '0;
      end else if (deb_q == DW'(DEB_TICKS - 1)) begin
        level_d = s;
        deb_d   = '0;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (EDGE_MODE)
      0:       edge_sel = level_d1_q & ~level_q;
      1:       edge_sel = ~level_d1_q & level_q;
      default: edge_sel = level_d1_q ^ level_q;
    endcase
  end

  // Release is taken from the next-state level so it beats a threshold on the same edge.
  assign released = (level_d != PRESS);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    if (released) begin
      state_d = S_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (level_q == PRESS) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end
        end
        S_HOLD: begin
          if (iEnClk) begin
            if (hold_q == HW'(LONG_TICKS - 1)) begin
              long_d  = 1'b1;
              hold_d  = '0;
              state_d = S_REPEAT;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if ((REPEAT_TICKS != 0) && iEnClk) begin
            if (hold_q == HW'(REPEAT_TICKS - 1)) begin
              rep_d  = 1'b1;
              hold_d = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      deb_q        <= '0;
      level_q      <= IDLE;
      level_d1_q   <= IDLE;
      sync_pulse_q <= 1'b0;
      state_q      <= S_IDLE;
      hold_q       <= '0;
      long_q       <= 1'b0;
      rep_q        <= 1'b0;
    end else begin
      deb_q        <= deb_d;
      level_q      <= level_d;
      level_d1_q   <= level_q;
      sync_pulse_q <= edge_sel;
      state_q      <= state_d;
      hold_q       <= hold_d;
      long_q       <= long_d;
      rep_q        <= rep_d;
    end
  end

  assign oLevel      = level_q;
  assign oSyncButton = sync_pulse_q;
  assign oLongPress  = long_q;
  assign oRepeat     = rep_q;

endmodule

module button_conditioner #(
  parameter int NUM_CH       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int PRESS_LEVEL  = 0,
  parameter int DEB_TICKS    = 4,
  parameter int EDGE_MODE    = 0,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iEnClk,
  input  logic [NUM_CH-1:0] iButton,
  output logic [NUM_CH-1:0] oLevel,
  output logic [NUM_CH-1:0] oSyncButton,
  output logic [NUM_CH-1:0] oLongPress,
  output logic [NUM_CH-1:0] oRepeat
);

  button_conditioner_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .PRESS_LEVEL (PRESS_LEVEL),
    .DEB_TICKS   (DEB_TICKS),
    .EDGE_MODE   (EDGE_MODE),
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_lane [NUM_CH-1:0] (
    .iClk       (iClk),
    .iRsn       (iRsn),
    .iEnClk     (iEnClk),
    .iButton    (iButton),
    .oLevel     (oLevel),
    .oSyncButton(oSyncButton),
    .oLongPress (oLongPress),
    .oRepeat    (oRepeat)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: falling-edge instance (a) and both-edge instance (b) share the same pins.

module tb_button_conditioner;

  logic       iClk, iRsn, iEnClk;
  logic [3:0] iButton;
  logic [3:0] lvl_a, sb_a, lp_a, rp_a;
  logic [3:0] lvl_b, sb_b, lp_b, rp_b;

  int total = 0;
  int bad   = 0;
  int sba[4], sbb[4], lpa[4], rpa[4], lpb[4], rpb[4];
  int lp_at[4], rp_first[4], rp_last[4];
  int tick_n;

  button_conditioner dut_a (
    .iClk(iClk), .iRsn(iRsn), .iEnClk(iEnClk), .iButton(iButton),
    .oLevel(lvl_a), .oSyncButton(sb_a), .oLongPress(lp_a), .oRepeat(rp_a)
  );

  button_conditioner #(.EDGE_MODE(2)) dut_b (
    .iClk(iClk), .iRsn(iRsn), .iEnClk(iEnClk), .iButton(iButton),
    .oLevel(lvl_b), .oSyncButton(sb_b), .oLongPress(lp_b), .oRepeat(rp_b)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < 4; c++) begin
      sba[c] = 0; sbb[c] = 0; lpa[c] = 0; rpa[c] = 0; lpb[c] = 0; rpb[c] = 0;
      lp_at[c] = -1; rp_first[c] = -1; rp_last[c] = -1;
    end
    tick_n = 0;
  endtask

  // one iClk cycle with the given strobe, then sample outputs 1ns after the edge
  task automatic clk1(input logic en);
    iEnClk = en;
    @(posedge iClk);
    #1;
    if (en) tick_n++;
    for (int c = 0; c < 4; c++) begin
      if (sb_a[c]) sba[c]++;
      if (sb_b[c]) sbb[c]++;
      if (lp_b[c]) lpb[c]++;
      if (rp_b[c]) rpb[c]++;
      if (lp_a[c]) begin lpa[c]++; lp_at[c] = tick_n; end
      if (rp_a[c]) begin
        if (rpa[c] == 0) rp_first[c] = tick_n;
        rpa[c]++;
        rp_last[c] = tick_n;
      end
    end
  endtask

  // one tick = strobe cycle followed by three quiet cycles
  task automatic ticks(input int n);
    repeat (n) begin
      clk1(1'b1);
      clk1(1'b0); clk1(1'b0); clk1(1'b0);
    end
  endtask

  function automatic int sum4(input int a[4]);
    return a[0] + a[1] + a[2] + a[3];
  endfunction

  initial begin
    iRsn = 1'b0; iButton = 4'hF; iEnClk = 1'b0;
    clr();
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_level", lvl_a, 4'hF);
    chk("rst_pulses", {sb_a, lp_a, rp_a}, 12'h000);
    iRsn = 1'b1;

    // 1: idle after reset, 50 ticks of silence
    clr();
    ticks(50);
    chk("t1_level_a", lvl_a, 4'hF);
    chk("t1_level_b", lvl_b, 4'hF);
    chk("t1_quiet_a", sum4(sba) + sum4(lpa) + sum4(rpa), 0);
    chk("t1_quiet_b", sum4(sbb) + sum4(lpb) + sum4(rpb), 0);

    // 2: ch0 press, accepted on the 4th tick after the synchroniser
    clr();
    iButton[0] = 1'b0;
    clk1(1'b0); clk1(1'b0);
    ticks(3);
    chk("t2_lvl_before", lvl_a[0], 1'b1);
    ticks(1);
    chk("t2_lvl_after", lvl_a[0], 1'b0);
    chk("t2_sync_ch0", sba[0], 1);
    chk("t2_sync_others", sba[1] + sba[2] + sba[3], 0);
    chk("t2_sync_b_ch0", sbb[0], 1);
    clr();
    iButton[0] = 1'b1;
    clk1(1'b0); clk1(1'b0);
    ticks(6);
    chk("t2_rel_lvl", lvl_a[0], 1'b1);
    chk("t2_rel_no_fall", sba[0], 0);
    chk("t2_rel_b_rise", sbb[0], 1);
    chk("t2_rel_no_long", lpa[0], 0);

    // 3: ch1 glitch of 3 ticks is rejected
    clr();
    iButton[1] = 1'b0;
    clk1(1'b0); clk1(1'b0);
    ticks(3);
    iButton[1] = 1'b1;
    clk1(1'b0); clk1(1'b0);
    ticks(10);
    chk("t3_lvl", lvl_a[1], 1'b1);
    chk("t3_sync_a", sba[1], 0);
    chk("t3_sync_b", sbb[1], 0);
    chk("t3_long_rep", lpa[1] + rpa[1], 0);

    // 4: ch2 held 145 ticks after debounce
    clr();
    iButton[2] = 1'b0;
    clk1(1'b0); clk1(1'b0);
    ticks(4);
    chk("t4_lvl", lvl_a[2], 1'b0);
    tick_n = 0;
    ticks(145);
    chk("t4_long_cnt", lpa[2], 1);
    chk("t4_long_at", lp_at[2], 100);
    chk("t4_rep_cnt", rpa[2], 2);
    chk("t4_rep_first", rp_first[2], 120);
    chk("t4_rep_last", rp_last[2], 140);
    iButton[2] = 1'b1;
    clk1(1'b0); clk1(1'b0);
    ticks(30);
    chk("t4_rel_lvl", lvl_a[2], 1'b1);
    chk("t4_rel_long", lpa[2], 1);
    chk("t4_rel_rep", rpa[2], 2);
    chk("t4_other_long", lpa[0] + lpa[1] + lpa[3], 0);

    // 5: ch3 press and release, both-edge instance pulses twice
    clr();
    iButton[3] = 1'b0;
    clk1(1'b0); clk1(1'b0);
    ticks(6);
    iButton[3] = 1'b1;
    clk1(1'b0); clk1(1'b0);
    ticks(6);
    chk("t5_sync_a", sba[3], 1);
    chk("t5_sync_b", sbb[3], 2);
    chk("t5_lvl_b", lvl_b[3], 1'b1);

    // 6: reset at hold tick 60 on ch0, pin kept low
    clr();
    iButton[0] = 1'b0;
    clk1(1'b0); clk1(1'b0);
    ticks(4);
    chk("t6_lvl_pressed", lvl_a[0], 1'b0);
    ticks(60);
    iRsn = 1'b0;
    #1;
    chk("t6_rst_lvl_a", lvl_a, 4'hF);
    chk("t6_rst_lvl_b", lvl_b, 4'hF);
    chk("t6_rst_pulses", {sb_a, lp_a, rp_a}, 12'h000);
    clk1(1'b0); clk1(1'b0);
    iRsn = 1'b1;
    clr();
    clk1(1'b0); clk1(1'b0);
    ticks(3);
    chk("t6_redeb_before", lvl_a[0], 1'b1);
    ticks(1);
    chk("t6_redeb_after", lvl_a[0], 1'b0);
    ticks(50);
    chk("t6_sync", sba[0], 1);
    chk("t6_no_long", lpa[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
